// File: rtl/valu_pkg.sv
// Shared encodings for the vector ALU sequencer: alucontrol codes and FSM states.
package valu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_MUL  = 3'b000;
  localparam logic [2:0] ALU_VSUM = 3'b011;
  localparam logic [2:0] ALU_VSET = 3'b111;
  localparam logic [2:0] ALU_SKIP = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  // Anything the lane datapath does not implement (100, 001, 101) passes srca through.
  function automatic logic is_skip(input logic [2:0] op);
    return !(op inside {ALU_ADD, ALU_SUB, ALU_MUL, ALU_VSUM, ALU_VSET});
  endfunction

endpackage

// File: rtl/valu_lane.sv
// Combinational single-lane datapath shared by all lanes of the sequencer.
module valu_lane
  import valu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] r_o
);

  logic signed [2*WIDTH-1:0] ax, bx, prod, prod_sh;
  logic                      unused_prod;

  // Full-width signed product, rescaled by FRAC; the upper bits are dropped (wraps, no saturation).
  assign ax          = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign bx          = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod        = ax * bx;
  assign prod_sh     = prod >>> FRAC;
  assign unused_prod = ^prod_sh[2*WIDTH-1:WIDTH];

  always_comb begin
    r_o = a_i;
    case (op_i)
      ALU_ADD:  r_o = a_i + b_i;
      ALU_SUB:  r_o = a_i - b_i;
      ALU_MUL:  r_o = prod_sh[WIDTH-1:0];
      ALU_VSUM: r_o = acc_i + a_i;
      ALU_VSET: r_o = b_i;
      default:  r_o = a_i;
    endcase
  end

endmodule

// File: rtl/valu_sequencer.sv
// Vector ALU sequencer: walks one lane per cycle through a shared valu_lane and
// holds the finished vector under a valid/ready handshake.
module valu_sequencer
  import valu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int FRAC  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             alucontrol,
  input  logic                   vector,
  input  logic [LANES*WIDTH-1:0] srca,
  input  logic [LANES*WIDTH-1:0] srcb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic                   zero,
  output logic                   busy
);

  localparam int CW = $clog2(LANES);
  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic           vec_q, vec_d;
  vec_t           a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d, last;
  logic           out_valid_q, out_valid_d, zero_q, zero_d;
  logic [WIDTH-1:0] lane_a, lane_b, lane_r;

  // vset broadcasts b[0], so the b mux ignores the lane index for that op.
  assign lane_a = a_q[cnt_q];
  assign lane_b = (op_q == ALU_VSET) ? b_q[0] : b_q[cnt_q];
  assign last   = vec_q ? CW'(LANES - 1) : '0;

  valu_lane #(.WIDTH(WIDTH), .FRAC(FRAC)) u_lane (
    .op_i  (op_q),
    .a_i   (lane_a),
    .b_i   (lane_b),
    .acc_i (acc_q),
    .r_o   (lane_r)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vec_d   = vec_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        op_d    = alucontrol;
        vec_d   = vector;
        a_d     = srca;
        b_d     = srcb;
        cnt_d   = '0;
        acc_d   = '0;
        res_d   = is_skip(alucontrol) ? vec_t'(srca) : '0;
        state_d = is_skip(alucontrol) ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        if (op_q == ALU_VSUM) begin
          acc_d    = lane_r;
          res_d[0] = lane_r;
        end else begin
          res_d[cnt_q] = lane_r;
        end
        if (cnt_q == last) state_d = S_DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_DONE);
    zero_d      = (state_d == S_DONE) && (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= ALU_SKIP;
      vec_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      vec_q       <= vec_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_valu_sequencer.sv
// Directed bench for valu_sequencer: latency, lane results, zero flag, backpressure and reset.
module tb_valu_sequencer;

  localparam int W = 32;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     alucontrol = 3'b010;
  logic           vector = 1'b0;
  logic [L*W-1:0] srca = '0, srcb = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [L*W-1:0] result;
  logic           zero;
  logic           busy;

  int nchk = 0;
  int nerr = 0;

  valu_sequencer #(.WIDTH(W), .LANES(L), .FRAC(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .vector(vector), .srca(srca), .srcb(srcb),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Presents one op for a single cycle; returns just after the accepting edge (at a negedge).
  task automatic issue(input logic [2:0] op, input logic vec,
                       input logic [L*W-1:0] a, input logic [L*W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1; alucontrol = op; vector = vec; srca = a; srcb = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Negedges after the accepting edge until out_valid; 99 means it never arrived.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nchk++; if (result !== '0) begin nerr++; $display("FAIL reset_result: got %h want 0", result); end
    nchk++; if (zero !== 1'b0) begin nerr++; $display("FAIL reset_zero: got %b want 0", zero); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready_hi: got %b want 0", in_ready); end
    reset = 1'b0;
    @(negedge clk);
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready_lo: got %b want 1", in_ready); end
  endtask

  task automatic test_vec_add();
    int lat;
    issue(3'b010, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10});
    nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL add_busy: got %b want 1", busy); end
    wait_valid(lat);
    nchk++; if (lat !== 5) begin nerr++; $display("FAIL add_latency: got %0d want 5", lat); end
    nchk++; if (result !== {32'd44, 32'd33, 32'd22, 32'd11}) begin nerr++; $display("FAIL add_result: got %h want %h", result, {32'd44, 32'd33, 32'd22, 32'd11}); end
    nchk++; if (zero !== 1'b0) begin nerr++; $display("FAIL add_zero: got %b want 0", zero); end
    consume();
    nchk++; if (in_ready !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL add_back_idle: got rdy=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_sub();
    int lat;
    issue(3'b110, 1'b1, {32'h80000000, 32'd100, 32'd0, 32'd5}, {32'd1, 32'd100, 32'd1, 32'd3});
    wait_valid(lat);
    nchk++; if (result !== {32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h2}) begin nerr++; $display("FAIL sub_result: got %h want %h", result, {32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h2}); end
    consume();
  endtask

  task automatic test_mul();
    int lat;
    // Scalar: upper lanes carry junk that must not leak into the result.
    issue(3'b000, 1'b0, {32'h7, 32'h7, 32'h7, 32'h00018000}, {32'h9, 32'h9, 32'h9, 32'h00020000});
    wait_valid(lat);
    nchk++; if (lat !== 2) begin nerr++; $display("FAIL mul_scalar_latency: got %0d want 2", lat); end
    nchk++; if (result !== {96'h0, 32'h00030000}) begin nerr++; $display("FAIL mul_scalar_result: got %h want %h", result, {96'h0, 32'h00030000}); end
    consume();
    // Vector with signed operands: 1.5*2, -1.5*2, 0.5*0.5, 1*-1.
    issue(3'b000, 1'b1, {32'h00010000, 32'h00008000, 32'hFFFE8000, 32'h00018000},
                        {32'hFFFF0000, 32'h00008000, 32'h00020000, 32'h00020000});
    wait_valid(lat);
    nchk++; if (result !== {32'hFFFF0000, 32'h00004000, 32'hFFFD0000, 32'h00030000}) begin nerr++; $display("FAIL mul_vector_result: got %h want %h", result, {32'hFFFF0000, 32'h00004000, 32'hFFFD0000, 32'h00030000}); end
    consume();
  endtask

  task automatic test_vsum();
    int lat;
    issue(3'b011, 1'b1, {32'hFFFFFFFB, 32'd5, 32'd1, 32'hFFFFFFFF}, {L*W{1'b1}});
    wait_valid(lat);
    nchk++; if (lat !== 5) begin nerr++; $display("FAIL vsum_latency: got %0d want 5", lat); end
    nchk++; if (result !== '0) begin nerr++; $display("FAIL vsum_zero_result: got %h want 0", result); end
    nchk++; if (zero !== 1'b1) begin nerr++; $display("FAIL vsum_zero_flag: got %b want 1", zero); end
    consume();
    issue(3'b011, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, '0);
    wait_valid(lat);
    nchk++; if (result !== {96'h0, 32'd10}) begin nerr++; $display("FAIL vsum_result: got %h want %h", result, {96'h0, 32'd10}); end
    nchk++; if (zero !== 1'b0) begin nerr++; $display("FAIL vsum_nonzero_flag: got %b want 0", zero); end
    consume();
  endtask

  task automatic test_vset_backpressure();
    int lat;
    logic [L*W-1:0] exp;
    exp = {4{32'h00001234}};
    issue(3'b111, 1'b1, '0, {32'h4, 32'h3, 32'h2, 32'h00001234});
    wait_valid(lat);
    nchk++; if (lat !== 5) begin nerr++; $display("FAIL vset_latency: got %0d want 5", lat); end
    // A competing request is offered while the result is held; it must be ignored.
    in_valid = 1'b1; alucontrol = 3'b010; srca = '1; srcb = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nchk++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp) begin
        nerr++; $display("FAIL vset_hold%0d: got v=%b rdy=%b r=%h want 1/0/%h", i, out_valid, in_ready, result, exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    nchk++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL vset_release: got busy=%b rdy=%b v=%b want 0/1/0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_skip();
    int lat;
    logic [2:0] codes [3];
    logic [L*W-1:0] a;
    codes = '{3'b100, 3'b001, 3'b101};
    a = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A50000, 32'h0000A5A5};
    foreach (codes[k]) begin
      issue(codes[k], k[0], a, '1);
      wait_valid(lat);
      nchk++; if (lat !== 1) begin nerr++; $display("FAIL skip_latency_%b: got %0d want 1", codes[k], lat); end
      nchk++; if (result !== a) begin nerr++; $display("FAIL skip_result_%b: got %h want %h", codes[k], result, a); end
      consume();
    end
  endtask

  task automatic test_reset_mid_exec();
    int lat;
    issue(3'b110, 1'b1, {32'd9, 32'd9, 32'd9, 32'd9}, {32'd1, 32'd1, 32'd1, 32'd1});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nchk++; if (busy !== 1'b0 || out_valid !== 1'b0 || result !== '0) begin
      nerr++; $display("FAIL midreset_state: got busy=%b v=%b r=%h want 0/0/0", busy, out_valid, result);
    end
    // Operands are scrambled right after acceptance; the latched copy must be used.
    issue(3'b010, 1'b1, {32'd100, 32'd200, 32'd300, 32'hFFFFFFFF}, {32'd1, 32'd2, 32'd3, 32'd1});
    srca = '1; srcb = '1; alucontrol = 3'b000;
    wait_valid(lat);
    nchk++; if (lat !== 5) begin nerr++; $display("FAIL midreset_add_latency: got %0d want 5", lat); end
    nchk++; if (result !== {32'd101, 32'd202, 32'd303, 32'd0}) begin nerr++; $display("FAIL midreset_add_result: got %h want %h", result, {32'd101, 32'd202, 32'd303, 32'd0}); end
    consume();
  endtask

  initial begin
    test_reset();
    test_vec_add();
    test_sub();
    test_mul();
    test_vsum();
    test_vset_backpressure();
    test_skip();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
